// File: rtl/mmio_pkg.sv
//------------------------------------------------------------------------------
// mmio_pkg: shared types and register map for the MMIO initiator. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_TIMEOUT  = 2'd1,
    RSP_MISALIGN = 2'd2
  } rsp_status_t;

  localparam logic [15:0] MMIO_BASE_HI = 16'hBEEF;

  localparam logic [15:0] MMIO_CONFIG  = 16'h0000;
  localparam logic [15:0] MMIO_INPUT   = 16'h0004;
  localparam logic [15:0] MMIO_OUTPUT  = 16'h0008;
  localparam logic [15:0] MMIO_STATUS  = 16'h000C;

endpackage

`default_nettype wire

// File: rtl/mmio_sat_counter.sv
//------------------------------------------------------------------------------
// mmio_sat_counter: saturating event counter, adds inc_i per cycle. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmio_sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W:0]   w_sum;

  // One spare bit catches the carry so the count pins at all-ones.
  assign w_sum = {1'b0, cnt_q} + (W+1)'(inc_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (w_sum[W]) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= w_sum[W-1:0];
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mmio_initiator.sv
//------------------------------------------------------------------------------
// mmio_initiator: single-command MMIO bus initiator with read timeout. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmio_initiator
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_HI        = MMIO_BASE_HI,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          STAT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [15:0]       cmd_offset_i,
  input  logic [31:0]       cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_status_o,
  output logic [31:0]       bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  output logic              bus_wr_o,
  output logic              bus_rd_o,
  input  logic              bus_rd_valid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic [STAT_W-1:0] stat_wr_cnt_o,
  output logic [STAT_W-1:0] stat_rd_cnt_o,
  output logic [STAT_W-1:0] stat_err_cnt_o
);

  localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  rsp_status_t        status_q, status_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic               write_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;

  logic               w_accept;
  logic               w_misalign;
  logic               w_timeout;
  logic               w_stray;
  logic [1:0]         w_err_inc;

  assign w_accept   = (state_q == IDLE) && cmd_valid_i;
  assign w_misalign = (cmd_offset_i[1:0] != 2'b00);
  assign w_timeout  = (state_q == WAIT) && !bus_rd_valid_i && (tcnt_q == TCNT_LAST);
  assign w_stray    = bus_rd_valid_i && (state_q != WAIT);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    tcnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (w_misalign) begin
            state_d  = RESP;
            status_d = RSP_MISALIGN;
            rdata_d  = '0;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = write_q ? IDLE : WAIT;
      WAIT: begin
        // A valid landing on the final count still wins over the timeout.
        if (bus_rd_valid_i) begin
          state_d  = RESP;
          status_d = RSP_OK;
          rdata_d  = bus_rdata_i;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d  = RESP;
          status_d = RSP_TIMEOUT;
          rdata_d  = '0;
        end else begin
          tcnt_d   = tcnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= RSP_OK;
      rdata_q  <= '0;
      tcnt_q   <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      tcnt_q   <= tcnt_d;
      if (w_accept) begin
        write_q <= cmd_write_i;
      end
      // Misaligned commands never reach the bus, so the bus view keeps its last access.
      if (w_accept && !w_misalign) begin
        addr_q  <= {BASE_HI, cmd_offset_i};
        wdata_q <= cmd_wdata_i;
      end
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_status_o = status_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign bus_wr_o     = (state_q == ISSUE) && write_q;
  assign bus_rd_o     = (state_q == ISSUE) && !write_q;

  // A stray valid can coincide with a misaligned accept, so errors may add two at once.
  assign w_err_inc = 2'(w_stray) + 2'(w_timeout | (w_accept & w_misalign));

  mmio_sat_counter #(.W(STAT_W), .INC_W(1)) u_stat_wr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bus_wr_o),
    .cnt_o (stat_wr_cnt_o)
  );

  mmio_sat_counter #(.W(STAT_W), .INC_W(1)) u_stat_rd (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bus_rd_o),
    .cnt_o (stat_rd_cnt_o)
  );

  mmio_sat_counter #(.W(STAT_W), .INC_W(2)) u_stat_err (
    .clk   (clk),
    .rst   (rst),
    .inc_i (w_err_inc),
    .cnt_o (stat_err_cnt_o)
  );

endmodule

`default_nettype wire
